// File: rtl/display_bcd_formatter_pkg.sv
// Shared definitions for the display BCD formatter.
// Contents: digit count, decimal range limit, segment patterns, FSM state
// type, BCD digit type and a helper that locates the most significant
// nonzero BCD digit.
package display_pkg;

  localparam int          DIGITS    = 8;
  localparam int unsigned MAX_DEC   = 32'd99_999_999;
  localparam logic [6:0]  SEG_DASH  = 7'h40;
  localparam logic [6:0]  SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // Index of the highest nonzero digit; 0 when the whole word is zero.
  function automatic logic [2:0] msd_index(input logic [31:0] bcd);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/display_bcd_formatter_if.sv
// Request/result bundle between a producer and the display BCD formatter.
// Producer side (master): start, value, dp.
// Formatter side (slave): busy, done, overflow, dis_data, dis_mode.
interface display_bcd_formatter_if #(
  parameter int BIN_W = 27
);
  logic             start;
  logic [BIN_W-1:0] value;
  logic [7:0]       dp;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [63:0]      dis_data;
  logic [7:0]       dis_mode;

  modport master (
    output start, value, dp,
    input  busy, done, overflow, dis_data, dis_mode
  );

  modport slave (
    input  start, value, dp,
    output busy, done, overflow, dis_data, dis_mode
  );
endinterface

// File: rtl/display_bcd_formatter_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
// Ports: digit_i - BCD digit before shift; digit_o - corrected digit.
module bcd_digit_adj
  import display_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  // Conditional add-3 correction
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/display_bcd_formatter.sv
// Binary-to-display formatter for an 8-digit 7-segment driver.
// Converts value to 8 BCD digits one bit per clock (double dabble), then
// packs digits, decimal points and blanking into dis_data/dis_mode.
// Values above 99,999,999 show a row of dashes and raise overflow.
// Ports: clk, reset (synchronous, active-high), bus (slave modport:
//   start/value/dp in; busy/done/overflow/dis_data/dis_mode out).
// Optional feature: define DISPLAY_BCD_LZB_EN for leading-zero blanking;
//   without it all eight digits are always shown.
module display_bcd_formatter
  import display_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input logic                    clk,
  input logic                    reset,
  display_bcd_formatter_if.slave bus
);

  localparam int CW = $clog2(BIN_W);

  state_e           state_q;
  logic [BIN_W-1:0] shift_q;
  logic [31:0]      bcd_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       dp_q;
  logic             ovf_flag_q;
  logic             busy_q;
  logic             done_q;
  logic             overflow_q;
  logic [63:0]      dis_data_q;
  logic [7:0]       dis_mode_q;

  logic [31:0]         bcd_adj_s;
  logic [31+BIN_W:0]   shifted_s;
  logic                over_s;
  logic [63:0]         dis_data_d;
  logic [7:0]          dis_mode_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj_s[4*g +: 4])
    );
  end

  // Corrected BCD and remaining binary bits move left together.
  assign shifted_s = {bcd_adj_s, shift_q} << 1;
  assign over_s    = 64'(bus.value) > 64'(MAX_DEC);

  // Build the display word from the finished BCD register
  always_comb begin
    dis_data_d = 64'h0;
    dis_mode_d = 8'h00;
    if (ovf_flag_q) begin
      for (int i = 0; i < DIGITS; i++) begin
        dis_data_d[8*i +: 8] = {dp_q[i], SEG_DASH};
      end
      dis_mode_d = 8'h00;
    end else begin
`ifdef DISPLAY_BCD_LZB_EN
      for (int i = 0; i < DIGITS; i++) begin
        // Digit 0 is always shown so a zero value reads "0".
        if (i == 0 || 3'(i) <= msd_index(bcd_q)) begin
          dis_data_d[8*i +: 8] = {dp_q[i], 3'b000, bcd_q[4*i +: 4]};
          dis_mode_d[i]        = 1'b1;
        end else begin
          dis_data_d[8*i +: 8] = {dp_q[i], SEG_BLANK};
          dis_mode_d[i]        = 1'b0;
        end
      end
`else
      for (int i = 0; i < DIGITS; i++) begin
        dis_data_d[8*i +: 8] = {dp_q[i], 3'b000, bcd_q[4*i +: 4]};
      end
      dis_mode_d = 8'hFF;
`endif
    end
  end

  // Control FSM, conversion datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= 32'h0;
      cnt_q      <= '0;
      dp_q       <= 8'h00;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      dis_data_q <= 64'h0;
      dis_mode_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q    <= bus.value;
            dp_q       <= bus.dp;
            bcd_q      <= 32'h0;
            cnt_q      <= CW'(BIN_W - 1);
            ovf_flag_q <= over_s;
            busy_q     <= 1'b1;
            // Out-of-range values skip conversion and go straight to dashes.
            state_q    <= over_s ? LOAD : CONVERT;
          end else begin
            state_q <= IDLE;
          end
        end
        CONVERT: begin
          bcd_q   <= shifted_s[31+BIN_W:BIN_W];
          shift_q <= shifted_s[BIN_W-1:0];
          if (cnt_q == '0) begin
            state_q <= LOAD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LOAD: begin
          dis_data_q <= dis_data_d;
          dis_mode_q <= dis_mode_d;
          overflow_q <= ovf_flag_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.dis_data = dis_data_q;
  assign bus.dis_mode = dis_mode_q;

endmodule

// File: tb/tb_display_bcd_formatter.sv
// Self-checking bench for display_bcd_formatter: a table of directed
// conversions plus hand-written sequences for reset, busy-start and
// back-to-back corner cases.
module tb_display_bcd_formatter;

  localparam int BIN_W = 27;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  display_bcd_formatter_if #(.BIN_W(BIN_W)) bus ();

  display_bcd_formatter #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BIN_W-1:0] value;
    logic [7:0]       dp;
    logic [63:0]      exp_data;
    logic [7:0]       exp_mode_lzb;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] exp_mode(input logic [7:0] lzb, input logic ovf);
    if (ovf) return 8'h00;
`ifdef DISPLAY_BCD_LZB_EN
    return lzb;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive a one-cycle start; returns at the falling edge after acceptance.
  task automatic issue(input logic [BIN_W-1:0] v, input logic [7:0] d);
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = v;
    bus.dp    = d;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // From the cycle after acceptance, count edges until done and busy cycles.
  task automatic wait_done(output int lat, output int bcnt, output bit ok);
    ok   = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.done) begin
        ok  = 1'b1;
        lat = k;
        break;
      end
      if (bus.busy) bcnt++;
      @(posedge clk);
      @(negedge clk);
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat, bcnt, dones;
    bit ok;
    n_chk = 0;
    n_pass = 0;
    bus.start = 1'b0;
    bus.value = '0;
    bus.dp    = 8'h00;

    vecs[0] = '{27'd0,           8'h00, 64'h00000000_00000000, 8'h01, 1'b0};
    vecs[1] = '{27'd12_345_678,  8'h00, 64'h01020304_05060708, 8'hFF, 1'b0};
    vecs[2] = '{27'd1000,        8'h02, 64'h00000000_01008000, 8'h0F, 1'b0};
    vecs[3] = '{27'd100_000_000, 8'h00, 64'h40404040_40404040, 8'h00, 1'b1};
    vecs[4] = '{27'd99_999_999,  8'h00, 64'h09090909_09090909, 8'hFF, 1'b0};
    vecs[5] = '{27'd134_217_727, 8'hA5, 64'hC040C040_40C040C0, 8'h00, 1'b1};
    vecs[6] = '{27'd42,          8'hFF, 64'h80808080_80808482, 8'h03, 1'b0};
    vecs[7] = '{27'd9,           8'h80, 64'h80000000_00000009, 8'h01, 1'b0};
    vecs[8] = '{27'd10_000_000,  8'h00, 64'h01000000_00000000, 8'hFF, 1'b0};
    vecs[9] = '{27'd305,         8'h01, 64'h00000000_00030085, 8'h07, 1'b0};

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ovf",  64'(bus.overflow), 64'd0);
    check("rst_data", bus.dis_data, 64'h0);
    check("rst_mode", 64'(bus.dis_mode), 64'h0);
    reset = 1'b0;

    // Table-driven conversions
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].value, vecs[i].dp);
      bus.value = ~vecs[i].value;  // changes after acceptance must not matter
      bus.dp    = ~vecs[i].dp;
      wait_done(lat, bcnt, ok);
      check($sformatf("v%0d_data", i), bus.dis_data, vecs[i].exp_data);
      check($sformatf("v%0d_mode", i), 64'(bus.dis_mode), 64'(exp_mode(vecs[i].exp_mode_lzb, vecs[i].exp_ovf)));
      check($sformatf("v%0d_ovf", i), 64'(bus.overflow), 64'(vecs[i].exp_ovf));
      check($sformatf("v%0d_lat", i), 64'(lat), vecs[i].exp_ovf ? 64'd1 : 64'(BIN_W + 1));
      check($sformatf("v%0d_busycyc", i), 64'(bcnt), vecs[i].exp_ovf ? 64'd1 : 64'(BIN_W + 1));
      check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
      check($sformatf("v%0d_hold", i), bus.dis_data, vecs[i].exp_data);
    end

    // Start during CONVERT is ignored; exactly one done
    issue(27'd12_345_678, 8'h00);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.value = 27'd5;
    bus.dp    = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("busy_start_dones", 64'(dones), 64'd1);
    check("busy_start_data", bus.dis_data, 64'h01020304_05060708);

    // Start in the same cycle as done is accepted
    issue(27'd7, 8'h00);
    wait_done(lat, bcnt, ok);
    bus.start = 1'b1;
    bus.value = 27'd3;
    bus.dp    = 8'h00;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_first_data", bus.dis_data, 64'h00000000_00000007);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(lat, bcnt, ok);
    check("b2b_second_data", bus.dis_data, 64'h00000000_00000003);

    // Reset mid-CONVERT aborts without a done pulse
    issue(27'd77_777_777, 8'h00);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_data", bus.dis_data, 64'h0);
    check("abort_mode", 64'(bus.dis_mode), 64'h0);
    check("abort_done", 64'(bus.done), 64'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    issue(27'd42, 8'h00);
    wait_done(lat, bcnt, ok);
    check("after_abort_data", bus.dis_data, 64'h00000000_00000402);
    check("after_abort_mode", 64'(bus.dis_mode), 64'(exp_mode(8'h03, 1'b0)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
